// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stall vectors, exception codes and FSM states.
package pipeline_ctrl_pkg;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Bit order: [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB
    localparam logic [5:0] STALL_NONE = {6{NoStop}};
    localparam logic [5:0] STALL_IF   = {{4{NoStop}}, {2{Stop}}};
    localparam logic [5:0] STALL_ID   = {{3{NoStop}}, {3{Stop}}};
    localparam logic [5:0] STALL_EX   = {{2{NoStop}}, {4{Stop}}};
    localparam logic [5:0] STALL_MEM  = {NoStop, {5{Stop}}};

    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    typedef enum logic [0:0] {
        StRun   = 1'b0,
        StGuard = 1'b1
    } ctrl_state_e;

    // The deepest requesting stage wins; everything upstream of it stops too.
    function automatic logic [5:0] stall_decode(input logic req_if, input logic req_id,
                                                input logic req_ex, input logic req_mem);
        logic [5:0] vec;
        vec = STALL_NONE;
        if (req_mem)     vec = STALL_MEM;
        else if (req_ex) vec = STALL_EX;
        else if (req_id) vec = STALL_ID;
        else if (req_if) vec = STALL_IF;
        return vec;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall/redirect bundle between the pipeline stages and the central sequencer.
interface pipeline_ctrl_if;

    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;

    // master: the sequencer that drives stall/flush; slave: the pipeline stages.
    modport master (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  excepttype_i, cp0_epc_i,
        output stall, flush, new_pc
    );

    modport slave (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc
    );

endinterface

// File: rtl/stall_watchdog.sv
// Consecutive-stall watchdog: sets a sticky flag once the pipeline has been stalled
// for WDOG_CYCLES cycles in a row.
module stall_watchdog #(
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_any,
    input  logic flush,
    output logic stall_timeout
);

    localparam int unsigned CntW = $clog2(WDOG_CYCLES + 1);
    localparam logic [CntW-1:0] Limit = CntW'(WDOG_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush || !stall_any) begin
            cnt_d = '0;
        end else if (cnt_q != Limit) begin
            cnt_d = cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (cnt_d == Limit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: merges stage stall requests and MEM-stage exceptions into the
// stall vector and flush/redirect, with a one-cycle post-flush guard and stall counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter int unsigned WDOG_CYCLES = 1024,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.master  bus,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] exc_count
);

    ctrl_state_e state_q, state_d;
    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] new_pc_c;
    logic        stall_any;

    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] exc_count_q, exc_count_d;

    // Outputs are held at zero while reset is asserted, whatever the inputs do.
    always_comb begin
        state_d  = state_q;
        stall_c  = STALL_NONE;
        flush_c  = 1'b0;
        new_pc_c = '0;
        if (!rst) begin
            if (state_q == StRun && bus.excepttype_i != '0) begin
                flush_c  = 1'b1;
                new_pc_c = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
                state_d  = StGuard;
            end else begin
                stall_c = stall_decode(bus.stallreq_from_if, bus.stallreq_from_id,
                                       bus.stallreq_from_ex, bus.stallreq_from_mem);
                state_d = StRun;
            end
        end
    end

    assign stall_any = |stall_c;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        exc_count_d    = exc_count_q;
        if (stall_any && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (flush_c && !(&exc_count_q)) begin
            exc_count_d = exc_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StRun;
            stall_cycles_q <= '0;
            exc_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
            exc_count_q    <= exc_count_d;
        end
    end

    stall_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .stall_any    (stall_any),
        .flush        (flush_c),
        .stall_timeout(stall_timeout)
    );

    assign bus.stall    = stall_c;
    assign bus.flush    = flush_c;
    assign bus.new_pc   = new_pc_c;
    assign stall_cycles = stall_cycles_q;
    assign exc_count    = exc_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a cycle model pushes expected outputs, which are
// popped and compared as the DUT produces them.
module tb_pipeline_ctrl;

    localparam int WDOG = 8;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
    } comb_t;

    typedef struct packed {
        logic        timeout;
        logic [31:0] sc;
        logic [31:0] ec;
    } reg_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_timeout;
    logic [31:0] stall_cycles;
    logic [31:0] exc_count;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(
        .EXC_VECTOR (32'h0000_0020),
        .WDOG_CYCLES(WDOG),
        .CNT_W      (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .stall_timeout(stall_timeout),
        .stall_cycles (stall_cycles),
        .exc_count    (exc_count)
    );

    always #5 clk = ~clk;

    comb_t       comb_q[$];
    reg_t        reg_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    string       phase = "init";

    logic        m_guard;
    int          m_wd;
    logic        m_to;
    int unsigned m_sc;
    int unsigned m_ec;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
        end
    endtask

    task automatic drive_inputs(input logic [3:0] req, input logic [31:0] exc,
                                input logic [31:0] epc);
        bus.stallreq_from_if  = req[0];
        bus.stallreq_from_id  = req[1];
        bus.stallreq_from_ex  = req[2];
        bus.stallreq_from_mem = req[3];
        bus.excepttype_i      = exc;
        bus.cp0_epc_i         = epc;
    endtask

    task automatic model_reset();
        m_guard = 1'b0;
        m_wd    = 0;
        m_to    = 1'b0;
        m_sc    = 0;
        m_ec    = 0;
    endtask

    // One clock cycle; req = {mem, ex, id, if}. Called and returns at posedge + 1.
    task automatic cycle(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc);
        comb_t e;
        comb_t got_e;
        reg_t  r;
        reg_t  got_r;
        drive_inputs(req, exc, epc);
        e = '0;
        if (!m_guard && exc != 32'h0) begin
            e.flush  = 1'b1;
            e.new_pc = (exc == 32'h0000_000e) ? epc : 32'h0000_0020;
        end else if (req[3]) e.stall = 6'b011111;
        else if (req[2])     e.stall = 6'b001111;
        else if (req[1])     e.stall = 6'b000111;
        else if (req[0])     e.stall = 6'b000011;
        comb_q.push_back(e);

        @(negedge clk);
        got_e = comb_q.pop_front();
        check_eq("stall",  {26'b0, bus.stall}, {26'b0, got_e.stall});
        check_eq("flush",  {31'b0, bus.flush}, {31'b0, got_e.flush});
        check_eq("new_pc", bus.new_pc,         got_e.new_pc);

        if (e.stall != 6'b0) begin
            if (m_sc != 32'hffff_ffff) m_sc++;
            if (m_wd < WDOG) m_wd++;
        end else begin
            m_wd = 0;
        end
        if (m_wd == WDOG) m_to = 1'b1;
        if (e.flush) m_ec++;
        m_guard = e.flush;
        r.timeout = m_to;
        r.sc      = m_sc;
        r.ec      = m_ec;
        reg_q.push_back(r);

        @(posedge clk);
        #1;
        got_r = reg_q.pop_front();
        check_eq("stall_timeout", {31'b0, stall_timeout}, {31'b0, got_r.timeout});
        check_eq("stall_cycles",  stall_cycles,           got_r.sc);
        check_eq("exc_count",     exc_count,              got_r.ec);
    endtask

    // Asynchronous reset mid-cycle with active inputs; outputs must drop at once.
    task automatic do_reset();
        drive_inputs(4'b1111, 32'h1, 32'hdead_beef);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_stall",         {26'b0, bus.stall},     32'h0);
        check_eq("rst_flush",         {31'b0, bus.flush},     32'h0);
        check_eq("rst_new_pc",        bus.new_pc,             32'h0);
        check_eq("rst_stall_timeout", {31'b0, stall_timeout}, 32'h0);
        check_eq("rst_stall_cycles",  stall_cycles,           32'h0);
        check_eq("rst_exc_count",     exc_count,              32'h0);
        @(posedge clk);
        #1;
        drive_inputs(4'b0000, 32'h0, 32'h0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        phase = "reset";
        do_reset();

        phase = "priority";
        cycle(4'b0101, 32'h0, 32'h0);
        cycle(4'b1101, 32'h0, 32'h0);
        cycle(4'b0010, 32'h0, 32'h0);
        cycle(4'b0000, 32'h0, 32'h0);

        phase = "exc_over_stall";
        cycle(4'b1000, 32'h8, 32'h0);
        cycle(4'b1000, 32'h8, 32'h0);

        phase = "eret";
        cycle(4'b0000, 32'h0000_000e, 32'hbfc0_0100);
        cycle(4'b0000, 32'h0, 32'h0);

        phase = "held_exc";
        for (int i = 0; i < 4; i++) cycle(4'b0000, 32'h1, 32'h0);
        check_eq("held_exc_count", exc_count, 32'd4);
        cycle(4'b0000, 32'h0, 32'h0);

        phase = "reset_in_guard";
        cycle(4'b1000, 32'h1, 32'h0);
        do_reset();
        cycle(4'b0000, 32'h1, 32'h0);
        cycle(4'b0000, 32'h0, 32'h0);

        phase = "watchdog";
        do_reset();
        for (int i = 0; i < 7; i++) cycle(4'b0100, 32'h0, 32'h0);
        cycle(4'b0000, 32'h0, 32'h0);
        check_eq("no_timeout_after_7", {31'b0, stall_timeout}, 32'h0);
        for (int i = 0; i < 8; i++) cycle(4'b0100, 32'h0, 32'h0);
        cycle(4'b0000, 32'h0, 32'h0);
        check_eq("timeout_sticky", {31'b0, stall_timeout}, 32'h1);
        check_eq("stall_cycles_15", stall_cycles, 32'd15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
